// File: rtl/fetch_stage.sv
// fetch_stage: IF stage of the 5-stage MIPS pipeline.
//   Holds the PC, selects the next PC (sequential or ID redirect), drives the
//   combinational instruction-memory address and captures the IF/ID register.
//   Stall enables from the hazard unit override redirect and flush requests.
// Configuration:
//   FETCH_STALL_CNT_EN  when defined, adds the stall_count port: a saturating
//                       count of edges with pc_write=0, cleared only by reset.
module fetch_stage #(
  parameter int unsigned             ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]       RESET_PC = '0,
  parameter int unsigned             PC_INC   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pc_write,
  input  logic              ifid_write,
  input  logic              pc_src,
  input  logic [ADDR_W-1:0] pc_target,
  input  logic              ifid_flush,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       ifid_instr,
  output logic [ADDR_W-1:0] ifid_pc4,
  output logic              ifid_valid,
  output logic [4:0]        ifid_rs,
  output logic [4:0]        ifid_rt
`ifdef FETCH_STALL_CNT_EN
  ,
  output logic [31:0]       stall_count
`endif
);

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_plus;
  logic [ADDR_W-1:0] pc_redirect;

  // Sequential PC wraps modulo 2^ADDR_W; targets are forced to word alignment.
  assign pc_plus     = pc + ADDR_W'(PC_INC);
  assign pc_redirect = {pc_target[ADDR_W-1:2], 2'b00};

  assign imem_addr = pc;
  assign ifid_rs   = ifid_instr[25:21];
  assign ifid_rt   = ifid_instr[20:16];

  // PC register: holds while stalled, so a redirect seen during a stall is dropped.
  // NOTE: the reset branch sits in the sensitivity list with negedge rst_n so it
  // takes effect immediately; all state uses <= so every register samples
  // pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (pc_write) begin
      pc <= pc_src ? pc_redirect : pc_plus;
    end
  end

  // IF/ID register: flush loads a NOP bubble; ifid_write=0 blocks both.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifid_instr <= '0;
      ifid_pc4   <= '0;
      ifid_valid <= 1'b0;
    end else if (ifid_write) begin
      if (ifid_flush) begin
        ifid_instr <= '0;
        ifid_pc4   <= '0;
        ifid_valid <= 1'b0;
      end else begin
        ifid_instr <= imem_rdata;
        ifid_pc4   <= pc_plus;
        ifid_valid <= 1'b1;
      end
    end
  end

`ifdef FETCH_STALL_CNT_EN
  // Stall counter: counts PC-stall edges and sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
    end else if (!pc_write && (stall_count != 32'hFFFF_FFFF)) begin
      stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scenarios plus randomized stall/redirect/flush
// traffic, checked against a transaction-level model of the fetch stage.
module tb_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pc_write, ifid_write, pc_src, ifid_flush;
  logic [31:0] pc_target;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] ifid_instr, ifid_pc4;
  logic        ifid_valid;
  logic [4:0]  ifid_rs, ifid_rt;
`ifdef FETCH_STALL_CNT_EN
  logic [31:0] stall_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Memory contents: fixed word for directed test, else address-derived pattern.
  logic        force_en;
  logic [31:0] force_val;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  assign imem_rdata = force_en ? force_val : mem_word(imem_addr);

  fetch_stage #(.ADDR_W(32), .RESET_PC(RST_PC), .PC_INC(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pc_write   (pc_write),
    .ifid_write (ifid_write),
    .pc_src     (pc_src),
    .pc_target  (pc_target),
    .ifid_flush (ifid_flush),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .ifid_instr (ifid_instr),
    .ifid_pc4   (ifid_pc4),
    .ifid_valid (ifid_valid),
    .ifid_rs    (ifid_rs),
    .ifid_rt    (ifid_rt)
`ifdef FETCH_STALL_CNT_EN
    ,
    .stall_count(stall_count)
`endif
  );

  always #5 clk = ~clk;

  // Reference model state.
  logic [31:0] m_pc, m_instr, m_pc4, m_stall;
  logic        m_valid;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = RST_PC; m_instr = 0; m_pc4 = 0; m_valid = 0; m_stall = 0;
  endtask

  task automatic check_all(input string where);
    check({where, ".imem_addr"}, imem_addr, m_pc);
    check({where, ".instr"},     ifid_instr, m_instr);
    check({where, ".pc4"},       ifid_pc4, m_pc4);
    check({where, ".valid"},     32'(ifid_valid), 32'(m_valid));
    check({where, ".rs"},        32'(ifid_rs), 32'(m_instr[25:21]));
    check({where, ".rt"},        32'(ifid_rt), 32'(m_instr[20:16]));
`ifdef FETCH_STALL_CNT_EN
    check({where, ".stall_cnt"}, stall_count, m_stall);
`endif
  endtask

  // One clock: drive controls, advance model by the spec rules, check after the edge.
  task automatic cycle(input logic pw, input logic iw, input logic src,
                       input logic [31:0] tgt, input logic fl, input string where);
    logic [31:0] fetched;
    pc_write = pw; ifid_write = iw; pc_src = src; pc_target = tgt; ifid_flush = fl;
    fetched = force_en ? force_val : mem_word(m_pc);
    @(posedge clk);
    if (iw) begin
      if (fl) begin m_instr = 0; m_pc4 = 0; m_valid = 0; end
      else begin m_instr = fetched; m_pc4 = m_pc + 4; m_valid = 1; end
    end
    if (pw) m_pc = src ? (tgt & ~32'd3) : m_pc + 4;
    else if (m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
    #1;
    check_all(where);
  endtask

  // Reset pulse between edges: outputs must clear before any edge arrives.
  task automatic reset_pulse(input string where);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all(where);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [31:0] pc_before;

  initial begin
    rst_n = 1'b0; force_en = 1'b1; force_val = 32'h8C22_0004;
    pc_write = 1; ifid_write = 1; pc_src = 0; pc_target = 0; ifid_flush = 0;
    model_reset();
    @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;

    // 1: first fetch after reset release
    cycle(1, 1, 0, 0, 0, "first");
    check("t1.addr",  imem_addr, 32'h0040_0004);
    check("t1.instr", ifid_instr, 32'h8C22_0004);
    check("t1.pc4",   ifid_pc4, 32'h0040_0004);
    check("t1.rs",    32'(ifid_rs), 32'd1);
    check("t1.rt",    32'(ifid_rt), 32'd2);
    force_en = 1'b0;

    // 2: full stall for two edges
    cycle(0, 0, 0, 0, 0, "stall1");
    cycle(0, 0, 0, 0, 0, "stall2");
    check("t2.addr", imem_addr, 32'h0040_0004);

    // 3: redirect with misaligned target plus flush
    cycle(1, 1, 1, 32'h0040_0103, 1, "redir");
    check("t3.addr",  imem_addr, 32'h0040_0100);
    check("t3.valid", 32'(ifid_valid), 32'd0);

    // 4: redirect/flush during stall are dropped
    pc_before = m_pc;
    cycle(0, 0, 1, 32'h1234_5670, 1, "drop");
    cycle(1, 1, 0, 0, 0, "after_drop");
    check("t4.addr", imem_addr, pc_before + 32'd4);

    // independent enables
    cycle(1, 0, 0, 0, 0, "pc_only");
    cycle(0, 1, 0, 0, 0, "ifid_only");
    cycle(0, 1, 0, 0, 1, "flush_pc_stall");

    // 5: wrap at top of address space
    cycle(1, 1, 1, 32'hFFFF_FFFE, 0, "to_top");
    check("t5.top", imem_addr, 32'hFFFF_FFFC);
    cycle(1, 1, 0, 0, 0, "wrap");
    check("t5.addr", imem_addr, 32'h0000_0000);
    check("t5.pc4",  ifid_pc4, 32'h0000_0000);

    // 6: async reset mid-run after stalls and a pending redirect
    cycle(0, 0, 1, 32'h0000_8000, 1, "pre_rst");
    reset_pulse("midrst");
    cycle(1, 1, 0, 0, 0, "post_rst");

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic pw, iw, src, fl;
      logic [31:0] tgt;
      pw  = ($urandom_range(0, 3) != 0);
      iw  = ($urandom_range(0, 3) != 0);
      src = ($urandom_range(0, 4) == 0);
      fl  = ($urandom_range(0, 4) == 0);
      tgt = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                        : $urandom;
      if ($urandom_range(0, 59) == 0) reset_pulse("rnd_rst");
      else cycle(pw, iw, src, tgt, fl, "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
